plab4_net_router_output_ctrl: RTL and testbench

PLAB4_NET_ROUTER_OUTPUT_CTRL -- requirements
Module: plab4_net_RouterOutputCtrl

---
 rtl/plab4_net_router_output_ctrl.sv | 118 +++++++++++
 tb/tb_plab4_net_router_output_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_output_ctrl.sv
// Output-port controller for a 3-input ring router: round-robin arbitration
// with packet locking (wormhole) and credit-based flow control toward downstream.
module plab4_net_router_output_ctrl #(
  parameter  int p_num_credits = 4,
  localparam int c_cred_nbits  = $clog2(p_num_credits + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req,
  input  logic [2:0]              tail,
  input  logic                    credit_ret,
  output logic [2:0]              grant,
  output logic                    out_val,
  output logic [c_cred_nbits-1:0] num_free,
  output logic                    locked,
  output logic                    cred_err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  localparam logic [c_cred_nbits-1:0] c_max_cred = c_cred_nbits'(p_num_credits);

  logic [0:0]              state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [c_cred_nbits-1:0] num_free_q, num_free_d;
  logic                    cred_err_q, cred_err_d;

  logic       has_cred;
  logic [1:0] ptr_p1, ptr_p2;
  logic [1:0] win;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Handshake: grant[i] is both the switch select and the "pop" for input i's
  // head flit in the same cycle; out_val is the downstream valid and is only
  // raised when a credit is held, so downstream never has to apply backpressure.
  always_comb begin
    grant    = '0;
    win      = '0;
    has_cred = (num_free_q != '0);
    ptr_p1   = inc3(ptr_q);
    ptr_p2   = inc3(ptr_p1);
    if (state_q == S_LOCKED) begin
      if (has_cred && req[owner_q]) begin
        grant[owner_q] = 1'b1;
        win            = owner_q;
      end
    end else if (has_cred) begin
      if (req[ptr_q]) begin
        grant[ptr_q] = 1'b1;
        win          = ptr_q;
      end else if (req[ptr_p1]) begin
        grant[ptr_p1] = 1'b1;
        win           = ptr_p1;
      end else if (req[ptr_p2]) begin
        grant[ptr_p2] = 1'b1;
        win           = ptr_p2;
      end
    end
  end

  assign out_val = |grant;

  // A tail flit releases the port and moves priority past its sender;
  // a body/head flit pins the port to the winner.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (out_val) begin
      if (tail[win]) begin
        state_d = S_IDLE;
        ptr_d   = inc3(win);
      end else begin
        state_d = S_LOCKED;
        owner_d = win;
      end
    end
  end

  always_comb begin
    num_free_d = num_free_q;
    cred_err_d = cred_err_q;
    case ({out_val, credit_ret})
      2'b10: num_free_d = num_free_q - 1'b1;
      2'b01: begin
        if (num_free_q == c_max_cred) cred_err_d = 1'b1;
        else                          num_free_d = num_free_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      num_free_q <= c_max_cred;
      cred_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      num_free_q <= num_free_d;
      cred_err_q <= cred_err_d;
    end
  end

  assign num_free = num_free_q;
  assign locked   = (state_q == S_LOCKED);
  assign cred_err = cred_err_q;

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Bench for the router output controller: two instances (4 and 2 credits)
// checked every cycle against a behavioural model plus directed literal vectors.
module tb_plab4_net_router_output_ctrl;

  logic       clk;
  logic       reset = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] tail = '0;
  logic       credit_ret = 1'b0;

  logic [2:0] grant_a, grant_b;
  logic       out_val_a, out_val_b;
  logic [2:0] num_free_a;
  logic [1:0] num_free_b;
  logic       locked_a, locked_b;
  logic       cred_err_a, cred_err_b;

  int errors = 0;
  int checks = 0;

  // {sel, cred_err, locked, grant, num_free}; sel=0 -> 4-credit dut, sel=1 -> 2-credit dut
  logic [8:0] exp_q[$];

  plab4_net_router_output_ctrl #(.p_num_credits(4)) dut_a (
    .clk(clk), .reset(reset), .req(req), .tail(tail), .credit_ret(credit_ret),
    .grant(grant_a), .out_val(out_val_a), .num_free(num_free_a),
    .locked(locked_a), .cred_err(cred_err_a)
  );

  plab4_net_router_output_ctrl #(.p_num_credits(2)) dut_b (
    .clk(clk), .reset(reset), .req(req), .tail(tail), .credit_ret(credit_ret),
    .grant(grant_b), .out_val(out_val_b), .num_free(num_free_b),
    .locked(locked_b), .cred_err(cred_err_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int   cap[2] = '{4, 2};
  int   m_nf[2];
  int   m_owner[2];
  int   m_ptr[2];
  logic m_locked[2];
  logic m_err[2];

  function automatic logic [2:0] model_grant(int d);
    logic [2:0] g;
    int i;
    g = '0;
    if (m_nf[d] == 0) return g;
    if (m_locked[d]) begin
      g[m_owner[d]] = req[m_owner[d]];
      return g;
    end
    for (int k = 0; k < 3; k++) begin
      i = (m_ptr[d] + k) % 3;
      if (req[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [2:0] g;
    int w;
    int nf;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_nf[d]     <= cap[d];
        m_owner[d]  <= 0;
        m_ptr[d]    <= 0;
        m_locked[d] <= 1'b0;
        m_err[d]    <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        g = model_grant(d);
        w = 0;
        for (int k = 0; k < 3; k++) if (g[k]) w = k;
        if (g != 0) begin
          if (tail[w]) begin
            m_locked[d] <= 1'b0;
            m_ptr[d]    <= (w + 1) % 3;
          end else begin
            m_locked[d] <= 1'b1;
            m_owner[d]  <= w;
          end
        end
        nf = m_nf[d] - ((g != 0) ? 1 : 0) + (credit_ret ? 1 : 0);
        if (nf > cap[d]) begin
          nf = cap[d];
          m_err[d] <= 1'b1;
        end
        m_nf[d] <= nf;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] g;
    logic [8:0] e;
    logic [8:0] act;
    g = model_grant(0);
    chk("a_grant", 32'(grant_a), 32'(g));
    chk("a_out_val", 32'(out_val_a), 32'(g != 0));
    chk("a_num_free", 32'(num_free_a), 32'(m_nf[0]));
    chk("a_locked", 32'(locked_a), 32'(m_locked[0]));
    chk("a_cred_err", 32'(cred_err_a), 32'(m_err[0]));
    g = model_grant(1);
    chk("b_grant", 32'(grant_b), 32'(g));
    chk("b_out_val", 32'(out_val_b), 32'(g != 0));
    chk("b_num_free", 32'(num_free_b), 32'(m_nf[1]));
    chk("b_locked", 32'(locked_b), 32'(m_locked[1]));
    chk("b_cred_err", 32'(cred_err_b), 32'(m_err[1]));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[8]) act = {1'b1, cred_err_b, locked_b, grant_b, 1'b0, num_free_b};
      else      act = {1'b0, cred_err_a, locked_a, grant_a, num_free_a};
      chk("vector{sel,err,lock,grant,nf}", 32'(act), 32'(e));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [2:0] r, input logic [2:0] t,
                      input logic cr, input logic sel, input logic err,
                      input logic lck, input logic [2:0] g, input logic [2:0] nf);
    reset      = rst;
    req        = r;
    tail       = t;
    credit_ret = cr;
    exp_q.push_back({sel, err, lck, g, nf});
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    // reset state and 3-way round robin with tail flits
    step(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'd4);
    step(1, 3'b111, 3'b111, 0, 0, 0, 0, 3'b001, 3'd4);
    step(1, 3'b111, 3'b111, 0, 0, 0, 0, 3'b010, 3'd3);
    step(1, 3'b111, 3'b111, 0, 0, 0, 0, 3'b100, 3'd2);
    step(1, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'd1);
    step(1, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'd2);
    step(1, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'd3);
    step(1, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'd4);

    // multi-flit packet lock, then starvation at zero credits
    step(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'd4);
    step(1, 3'b011, 3'b000, 0, 0, 0, 0, 3'b001, 3'd4);
    step(1, 3'b011, 3'b000, 0, 0, 0, 1, 3'b001, 3'd3);
    step(1, 3'b011, 3'b001, 0, 0, 0, 1, 3'b001, 3'd2);
    step(1, 3'b011, 3'b000, 0, 0, 0, 0, 3'b010, 3'd1);
    step(1, 3'b000, 3'b000, 1, 0, 0, 1, 3'b000, 3'd0);
    step(1, 3'b011, 3'b010, 0, 0, 0, 1, 3'b010, 3'd1);
    step(1, 3'b011, 3'b000, 0, 0, 0, 0, 3'b000, 3'd0);
    step(1, 3'b011, 3'b000, 1, 0, 0, 0, 3'b000, 3'd0);
    step(1, 3'b011, 3'b001, 0, 0, 0, 0, 3'b001, 3'd1);

    // simultaneous send/return, then credit overflow is sticky
    step(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'd4);
    step(1, 3'b001, 3'b001, 0, 0, 0, 0, 3'b001, 3'd4);
    step(1, 3'b001, 3'b001, 0, 0, 0, 0, 3'b001, 3'd3);
    step(1, 3'b001, 3'b001, 0, 0, 0, 0, 3'b001, 3'd2);
    step(1, 3'b001, 3'b001, 1, 0, 0, 0, 3'b001, 3'd1);
    step(1, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'd1);
    step(1, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'd1);
    step(1, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'd2);
    step(1, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'd3);
    step(1, 3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 3'd4);
    step(1, 3'b000, 3'b000, 0, 0, 1, 0, 3'b000, 3'd4);
    step(1, 3'b000, 3'b000, 0, 0, 1, 0, 3'b000, 3'd4);

    // reset in the middle of a locked packet
    step(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'd4);
    step(1, 3'b100, 3'b000, 0, 0, 0, 0, 3'b100, 3'd4);
    step(1, 3'b100, 3'b000, 0, 0, 0, 1, 3'b100, 3'd3);
    step(0, 3'b101, 3'b000, 0, 0, 0, 0, 3'b001, 3'd4);
    step(1, 3'b101, 3'b000, 0, 0, 0, 0, 3'b001, 3'd4);
    step(1, 3'b101, 3'b001, 0, 0, 0, 1, 3'b001, 3'd3);
    step(1, 3'b101, 3'b010, 0, 0, 0, 0, 3'b100, 3'd2);
    step(1, 3'b101, 3'b000, 0, 0, 0, 1, 3'b100, 3'd1);

    // two-credit instance runs dry and resumes after one credit
    step(0, 3'b000, 3'b000, 0, 1, 0, 0, 3'b000, 3'd2);
    step(1, 3'b001, 3'b001, 0, 1, 0, 0, 3'b001, 3'd2);
    step(1, 3'b001, 3'b001, 0, 1, 0, 0, 3'b001, 3'd1);
    step(1, 3'b001, 3'b001, 0, 1, 0, 0, 3'b000, 3'd0);
    step(1, 3'b001, 3'b001, 0, 1, 0, 0, 3'b000, 3'd0);
    step(1, 3'b001, 3'b001, 1, 1, 0, 0, 3'b000, 3'd0);
    step(1, 3'b001, 3'b001, 0, 1, 0, 0, 3'b001, 3'd1);
    step(1, 3'b000, 3'b000, 0, 1, 0, 0, 3'b000, 3'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: time limit reached with %0d vectors pending", exp_q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
